// File: rtl/tdp_ram_port_arbiter_pkg.sv
// Shared types and helpers for the RAM port-A arbiter.
// Read latency codes match the attached RAM's modes.
package tdp_ram_arb_pkg;

    localparam int RD_LAT_HIGH_PERF = 2;
    localparam int RD_LAT_LOW_LAT   = 1;

    typedef enum logic {
        ST_UNLOCKED,
        ST_LOCKED
    } lock_state_e;

    function automatic int clogb2(input int depth);
        int d;
        int r;
        d = depth;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (d > 0) begin
                r = r + 1;
                d = d >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tdp_ram_port_arbiter_if.sv
// Requester-side command/response bundle for the arbiter.
// Slices of the flat buses belong to one requester each.
interface tdp_ram_port_arbiter_if
    import tdp_ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int RAM_WIDTH  = 18,
    parameter int ADDR_WIDTH = 10
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ-1:0]            req_lock;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*RAM_WIDTH-1:0]  req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [RAM_WIDTH-1:0]          rsp_rdata;

    modport master (
        output req_valid, req_we, req_lock,
        output req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_lock,
        input  req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/tdp_ram_port_arbiter_rr_arbiter.sv
// Round-robin one-hot grant starting at a rotating pointer.
// The mask removes requesters that may not win this cycle.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    input  logic [NUM_REQ-1:0] i_mask,
    output logic [NUM_REQ-1:0] o_grant
);

    logic [NUM_REQ-1:0] w_req;

    assign w_req = i_req & i_mask;

    // first masked requester at or after the pointer, wrapping
    always_comb begin
        int   idx;
        logic found;
        o_grant = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(i_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && w_req[idx]) begin
                o_grant[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdp_ram_port_arbiter.sv
// Shares RAM port A among requesters: lock FSM, registered
// RAM command and a read-tag pipeline routing data back.
module tdp_ram_port_arbiter
    import tdp_ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int RAM_WIDTH  = 18,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clka,
    input  logic                  rstb,
    tdp_ram_port_arbiter_if.slave s_bus,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [RAM_WIDTH-1:0]  ram_dina,
    output logic                  ram_regcea,
    output logic                  ram_rsta,
    input  logic [RAM_WIDTH-1:0]  ram_douta
);

    localparam int PW = clogb2(NUM_REQ - 1);

    generate
        if (RD_LATENCY != RD_LAT_HIGH_PERF &&
            RD_LATENCY != RD_LAT_LOW_LAT) begin : g_bad_latency
            $error("RD_LATENCY must be 1 or 2");
        end
    endgenerate

    lock_state_e        r_state;
    lock_state_e        w_state_nx;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      w_ptr_nx;
    logic [PW-1:0]      r_owner;
    logic [PW-1:0]      w_owner_nx;
    logic [PW-1:0]      w_sel;
    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_ready;
    logic [NUM_REQ-1:0] w_rd_tag;
    logic               w_acc;
    logic [NUM_REQ-1:0] r_tag [RD_LATENCY+1];

    // a held lock narrows arbitration to its owner
    always_comb begin
        w_mask = '1;
        if (r_state == ST_LOCKED) begin
            w_mask          = '0;
            w_mask[r_owner] = 1'b1;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PW)
    ) u_rr (
        .i_req   (s_bus.req_valid),
        .i_ptr   (r_ptr),
        .i_mask  (w_mask),
        .o_grant (w_grant)
    );

    assign w_ready         = rstb ? '0 : w_grant;
    assign s_bus.req_ready = w_ready;
    assign w_acc           = |w_ready;

    // index of the granted requester
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) w_sel = PW'(i);
        end
    end

    // lock FSM and pointer next state
    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_ptr_nx   = r_ptr;
        if (w_acc) begin
            if (s_bus.req_lock[w_sel]) begin
                w_state_nx = ST_LOCKED;
                w_owner_nx = w_sel;
            end else begin
                w_state_nx = ST_UNLOCKED;
                w_ptr_nx   = (w_sel == PW'(NUM_REQ - 1)) ?
                             '0 : w_sel + PW'(1);
            end
        end
    end

    assign w_rd_tag = (w_acc && !s_bus.req_we[w_sel]) ?
                      w_grant : '0;

    // lock FSM and pointer state
    always_ff @(posedge clka) begin
        if (rstb) begin
            r_state <= ST_UNLOCKED;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
            r_ptr   <= w_ptr_nx;
        end
    end

    // registered RAM port-A command from the winning slice
    always_ff @(posedge clka) begin
        if (rstb) begin
            ram_ena   <= 1'b0;
            ram_wea   <= 1'b0;
            ram_addra <= '0;
            ram_dina  <= '0;
        end else begin
            ram_ena <= w_acc;
            ram_wea <= w_acc & s_bus.req_we[w_sel];
            if (w_acc) begin
                ram_addra <= s_bus.req_addr[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
                ram_dina  <= s_bus.req_wdata[int'(w_sel)*RAM_WIDTH +: RAM_WIDTH];
            end
        end
    end

    // read tags ride alongside the RAM latency
    always_ff @(posedge clka) begin
        if (rstb) begin
            for (int i = 0; i <= RD_LATENCY; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= w_rd_tag;
            for (int i = 1; i <= RD_LATENCY; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    assign s_bus.rsp_valid = rstb ? '0 : r_tag[RD_LATENCY];
    assign s_bus.rsp_rdata = ram_douta;
    assign ram_regcea      = 1'b1;
    assign ram_rsta        = rstb;

endmodule
